// File: rtl/md_unit.sv
// md_unit - multi-cycle multiply/divide unit owning the HI/LO registers.
//
// Executes mult/multu (MUL_CYCLES busy cycles + 1 writeback cycle),
// div/divu (radix-2 restoring, WIDTH iterations + 1 writeback cycle)
// and the single-cycle mthi/mtlo moves. HI/LO change only at accept
// (mthi/mtlo) or at the end of a mul/div.
//
// Optional feature macro: MDU_CANCEL_EN
//   defined   - cancel aborts an in-flight op (HI/LO keep old values) and
//               blocks an accept presented in the same cycle.
//   undefined - cancel is ignored.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   md_valid  in   EX-stage instruction valid
//   md_func   in   0 none, 1 mthi, 2 mtlo, 3 mul, 4 div, 5-7 none
//   md_sign   in   1 signed, 0 unsigned
//   md_a      in   rs operand (dividend / multiplicand / move data)
//   md_b      in   rt operand (divisor / multiplier)
//   cancel    in   abort in-flight op (only with MDU_CANCEL_EN)
//   hi, lo    out  HI/LO registers
//   busy      out  registered, high while a mul/div is in flight
//
// state  | meaning
// S_IDLE | waiting; mthi/mtlo/mul/div accepted here
// S_MUL  | multiply latency countdown
// S_DIV  | one restoring-divide iteration per cycle
// S_DONE | sign fixup and HI/LO writeback, busy falls
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_valid,
  input  logic [2:0]       md_func,
  input  logic             md_sign,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  // a_q: multiplicand, or dividend magnitude that shifts into the quotient
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic             sign_q;
  logic             is_div_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;

  logic cancel_w;
`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_w      = 1'b0;
`endif

  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   trial_d;
  logic [2*WIDTH-1:0] ext_a_d;
  logic [2*WIDTH-1:0] ext_b_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0] quot_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  always_comb begin
    a_neg_d = md_sign & md_a[WIDTH-1];
    b_neg_d = md_sign & md_b[WIDTH-1];
    a_mag_d = a_neg_d ? (~md_a + 1'b1) : md_a;
    b_mag_d = b_neg_d ? (~md_b + 1'b1) : md_b;
    // Partial remainder never exceeds the divisor, so bit WIDTH of the
    // trial difference is a clean borrow flag (also holds for divisor 0).
    shift_d = {rem_q, a_q[WIDTH-1]};
    trial_d = shift_d - {1'b0, b_q};
    // Sign-extended operands multiplied modulo 2^(2W) give the signed product.
    ext_a_d = {{WIDTH{sign_q & a_q[WIDTH-1]}}, a_q};
    ext_b_d = {{WIDTH{sign_q & b_q[WIDTH-1]}}, b_q};
    prod_d  = ext_a_d * ext_b_d;
    quot_fix_d = qneg_q ? (~a_q + 1'b1) : a_q;
    rem_fix_d  = rneg_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_valid && !cancel_w) begin
            case (md_func)
              3'd1: hi_q <= md_a;
              3'd2: lo_q <= md_a;
              3'd3: begin
                a_q      <= md_a;
                b_q      <= md_b;
                sign_q   <= md_sign;
                is_div_q <= 1'b0;
                cnt_q    <= CW'(MUL_CYCLES - 1);
                busy_q   <= 1'b1;
                state_q  <= S_MUL;
              end
              3'd4: begin
                a_q      <= a_mag_d;
                b_q      <= b_mag_d;
                rem_q    <= '0;
                sign_q   <= md_sign;
                qneg_q   <= a_neg_d ^ b_neg_d;
                rneg_q   <= a_neg_d;
                is_div_q <= 1'b1;
                cnt_q    <= CW'(WIDTH - 1);
                busy_q   <= 1'b1;
                state_q  <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cancel_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          if (cancel_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            a_q   <= {a_q[WIDTH-2:0], ~trial_d[WIDTH]};
            rem_q <= trial_d[WIDTH] ? shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
            if (cnt_q == '0) state_q <= S_DONE;
            else             cnt_q   <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          if (!cancel_w) begin
            if (is_div_q) begin
              hi_q <= rem_fix_d;
              lo_q <= quot_fix_d;
            end else begin
              hi_q <= prod_d[2*WIDTH-1:WIDTH];
              lo_q <= prod_d[WIDTH-1:0];
            end
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit - directed scoreboard bench for md_unit.
// Stimulus pushes the expected {hi, lo, busy length} when it issues an op;
// the monitor pops and compares when busy falls or on an explicit check strobe.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [2:0]  md_func;
  logic        md_sign;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  md_unit #(.WIDTH(32), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .md_valid(md_valid), .md_func(md_func),
    .md_sign(md_sign), .md_a(md_a), .md_b(md_b), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy_cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_now = 1'b0;
  logic allow_busy_op = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    logic busy_prev;
    int   bcnt;
    exp_t e;
    busy_prev = 1'b0;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (busy_prev && md_valid && (md_func inside {[3'd1:3'd4]}) && !allow_busy_op) begin
        n_bad++;
        $display("FAIL busy_accept: op func=%0d presented while busy", md_func);
      end
      if (busy) bcnt++;
      if ((busy_prev && !busy) || chk_now) begin
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: hi=0x%08h lo=0x%08h with no expectation", hi, lo);
        end else begin
          e = sb_q.pop_front();
          cmp({e.name, ".hi"}, hi, e.hi);
          cmp({e.name, ".lo"}, lo, e.lo);
          if (chk_now)
            cmp({e.name, ".busy"}, {31'd0, busy}, 32'd0);
          else if (e.busy_cyc >= 0)
            cmp({e.name, ".busy_cycles"}, bcnt, e.busy_cyc);
        end
      end
      if (!busy) bcnt = 0;
      busy_prev = busy;
    end
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int bc, input string nm);
    exp_t e;
    e.hi = h; e.lo = l; e.busy_cyc = bc; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic start_op(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_valid = 1'b1; md_func = f; md_sign = s; md_a = a; md_b = b;
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_bad++;
      $display("FAIL %s.timeout: busy still 1 after %0d cycles, expected 0", nm, k);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int bc, input string nm);
    push(eh, el, bc, nm);
    start_op(f, s, a, b);
    wait_idle(nm);
  endtask

  task automatic chk(input logic [31:0] eh, input logic [31:0] el, input string nm);
    push(eh, el, 0, nm);
    @(negedge clk);
    chk_now = 1'b1;
    @(negedge clk);
    chk_now = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; md_valid = 1'b0; md_func = 3'd0; md_sign = 1'b0;
    md_a = '0; md_b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk(32'h0, 32'h0, "reset");

    // multiplies
    run(3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, "multu_max");
    run(3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, "mult_neg3x7");
    run(3'd3, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5, "multu_2p32");

    // divides
    run(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg7by2");
    run(3'd4, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, "div_7byneg2");
    run(3'd4, 1'b0, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 33, "divu_by0");
    run(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, "div_ovf");
    run(3'd4, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 33, "divu_big");

    // mthi / mtlo back to back
    @(negedge clk);
    md_valid = 1'b1; md_func = 3'd1; md_a = 32'h1234;
    @(negedge clk);
    md_func = 3'd2; md_a = 32'h5678;
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd0;
    chk(32'h1234, 32'h5678, "mthi_mtlo");

    // invalid / reserved ops change nothing
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd3; md_a = 32'd5; md_b = 32'd5;
    @(negedge clk);
    md_func = 3'd0;
    chk(32'h1234, 32'h5678, "mult_novalid");
    @(negedge clk);
    md_valid = 1'b1; md_func = 3'd5; md_a = 32'hDEAD;
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd0;
    chk(32'h1234, 32'h5678, "func5_none");

    // mul presented mid-divide is ignored
    push(32'd2, 32'd14, 33, "div_midmul");
    start_op(3'd4, 1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    allow_busy_op = 1'b1;
    md_valid = 1'b1; md_func = 3'd3; md_a = 32'd3; md_b = 32'd3;
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd0; allow_busy_op = 1'b0;
    wait_idle("div_midmul");

    // reset mid-divide clears everything at once
    push(32'h0, 32'h0, -1, "rst_middiv");
    start_op(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk(32'h0, 32'h0, "post_rst");

    // cancel behaviour
    start_op(3'd1, 1'b0, 32'hAA, 32'h0);
    start_op(3'd2, 1'b0, 32'hBB, 32'h0);
`ifdef MDU_CANCEL_EN
    push(32'hAA, 32'hBB, 2, "mult_cancel");
`else
    push(32'h0, 32'd30, 5, "mult_cancel");
`endif
    start_op(3'd3, 1'b0, 32'd5, 32'd6);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    wait_idle("mult_cancel");

    @(negedge clk);
    cancel = 1'b1; md_valid = 1'b1; md_func = 3'd1; md_a = 32'h77;
    @(negedge clk);
    cancel = 1'b0; md_valid = 1'b0; md_func = 3'd0;
`ifdef MDU_CANCEL_EN
    chk(32'hAA, 32'hBB, "cancel_blocks_accept");
`else
    chk(32'h77, 32'd30, "cancel_blocks_accept");
`endif

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expectations never matched, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
